hub_fbload: RTL and testbench

Framebuffer loader for the HUB75 path. Accepts an 8-bit RGB byte stream from the host link and packs it into a double-buffered pixel RAM. The HUB75 signal generator scans one RAM bank while this block fills the other. Completed frames are swapped in only at the scan's frame boundary, so the panel never shows a torn image.

---
 rtl/hub_fbload_pkg.sv | 29 ++
 rtl/hub_fbload_pixpack.sv | 57 +++++
 rtl/hub_fbload.sv | 179 +++++++++++++++++
 tb/tb_hub_fbload.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_fbload_pkg.sv
// ---------------------------------------------------------------------------
// hub_fbload_pkg
// Shared HUB75 definitions: scan geometry, framebuffer size, loader byte
// phase and state encodings, and the scan frame-boundary predicate used to
// time bank swaps.
// ---------------------------------------------------------------------------
package hub_fbload_pkg;

   localparam int SCAN_ADDR_W = 12;
   localparam int ROWS        = 16;
   localparam int COLS        = 256;
   localparam int PIX_TOTAL   = 8192;

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = SCAN_ADDR_W - COL_W;
   localparam int PIX_W = $clog2(PIX_TOTAL);

   typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_e;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FULL} state_e;

   // True on the generator's row-latch strobe for the last scan row: the
   // only moment at which the displayed bank may change without tearing.
   function automatic logic is_boundary(input logic                   fc,
                                        input logic [SCAN_ADDR_W-1:0] addr,
                                        input logic [ROW_W-1:0]       last_row);
      return fc && (addr[SCAN_ADDR_W-1 -: ROW_W] == last_row);
   endfunction

endpackage

// File: rtl/hub_fbload_pixpack.sv
// ---------------------------------------------------------------------------
// hub_pixpack
// Holds the R and G bytes of the pixel being assembled (truncated to DEPTH
// MSBs) and, while the B byte is on byte_i, presents the packed write word.
//
// Ports:
//   pin_clk, rst  clock, asynchronous active-high reset
//   byte_i        incoming stream byte
//   take_r_i      capture byte_i as the red channel
//   take_g_i      capture byte_i as the green channel
//   half_i        0: pixel goes to the upper half-word, 1: lower
//   data_o        {lower RGB, upper RGB}; inactive half driven to zero
//   mask_o        half-word enables, bit0 upper, bit1 lower
// ---------------------------------------------------------------------------
module hub_pixpack #(
   parameter int DEPTH = 4
) (
   input  logic                 pin_clk,
   input  logic                 rst,
   input  logic [7:0]           byte_i,
   input  logic                 take_r_i,
   input  logic                 take_g_i,
   input  logic                 half_i,
   output logic [6*DEPTH-1:0]   data_o,
   output logic [1:0]           mask_o
);

   localparam int PW = 3 * DEPTH;

   logic [DEPTH-1:0] r_q;
   logic [DEPTH-1:0] g_q;
   logic [PW-1:0]    pix;

   always_ff @(posedge pin_clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
         g_q <= '0;
      end else begin
         if (take_r_i) r_q <= byte_i[7 -: DEPTH];
         if (take_g_i) g_q <= byte_i[7 -: DEPTH];
      end
   end

   // B is not stored: the word is formed from the live byte so the write
   // can be registered on the same edge that accepts B.
   assign pix    = {r_q, g_q, byte_i[7 -: DEPTH]};
   assign data_o = half_i ? {pix, {PW{1'b0}}} : {{PW{1'b0}}, pix};
   assign mask_o = half_i ? 2'b10 : 2'b01;

   generate
      if (DEPTH < 8) begin : g_drop_lsbs
         logic unused_lsbs;
         assign unused_lsbs = ^byte_i[7-DEPTH:0];
      end
   endgenerate

endmodule

// File: rtl/hub_fbload.sv
// ---------------------------------------------------------------------------
// hub_fbload
// Framebuffer loader for the HUB75 path. Packs an R,G,B byte stream into
// the back bank of a double-buffered pixel RAM and swaps banks only at the
// scan's frame boundary.
//
// Ports:
//   pin_clk, rst      clock, asynchronous active-high reset
//   in_data/valid/sof byte stream; in_sof marks R of pixel 0
//   in_ready          byte accepted when in_valid & in_ready
//   scan_addr/scan_fc generator address ({row, col}) and row-latch strobe
//   wr_en/addr/data/mask  registered RAM write, addr = {bank, word}
//   disp_bank         bank currently scanned by the generator
//   swap_pulse        one-cycle bank swap marker
//   sync_err          one-cycle marker: in_sof arrived mid-frame
// ---------------------------------------------------------------------------
module hub_fbload
   import hub_fbload_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int LAST_ROW = ROWS - 1
) (
   input  logic                   pin_clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   input  logic                   in_sof,
   output logic                   in_ready,
   input  logic [SCAN_ADDR_W-1:0] scan_addr,
   input  logic                   scan_fc,
   output logic                   wr_en,
   output logic [PIX_W-1:0]       wr_addr,
   output logic [6*DEPTH-1:0]     wr_data,
   output logic [1:0]             wr_mask,
   output logic                   disp_bank,
   output logic                   swap_pulse,
   output logic                   sync_err
);

   localparam logic [ROW_W-1:0] LAST_ROW_L = ROW_W'(LAST_ROW);
   localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(PIX_TOTAL - 1);

   state_e               state_q, state_d;
   phase_e               phase_q, phase_d;
   logic [PIX_W-1:0]     pix_q, pix_d;
   logic                 disp_bank_q, disp_bank_d;
   logic                 swap_q, swap_d;
   logic                 sync_err_q, sync_err_d;
   logic                 wr_en_q, wr_en_d;
   logic [PIX_W-1:0]     wr_addr_q, wr_addr_d;
   logic [6*DEPTH-1:0]   wr_data_q, wr_data_d;
   logic [1:0]           wr_mask_q, wr_mask_d;

   logic                 accept;
   logic                 take_r;
   logic                 take_g;
   logic [6*DEPTH-1:0]   pack_data;
   logic [1:0]           pack_mask;
   logic [COL_W-1:0]     unused_scan_col;

   assign unused_scan_col = scan_addr[COL_W-1:0];

   assign in_ready = (state_q != ST_FULL);
   assign accept   = in_valid && in_ready;

   // in_sof always restarts at R, whatever phase the loader was in.
   assign take_r = accept && (in_sof || (state_q == ST_LOAD && phase_q == PH_R));
   assign take_g = accept && !in_sof && state_q == ST_LOAD && phase_q == PH_G;

   hub_pixpack #(.DEPTH(DEPTH)) u_pixpack (
      .pin_clk  (pin_clk),
      .rst      (rst),
      .byte_i   (in_data),
      .take_r_i (take_r),
      .take_g_i (take_g),
      .half_i   (pix_q[PIX_W-1]),
      .data_o   (pack_data),
      .mask_o   (pack_mask)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      pix_d       = pix_q;
      disp_bank_d = disp_bank_q;
      swap_d      = 1'b0;
      sync_err_d  = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_mask_d   = wr_mask_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && in_sof) begin
               phase_d = PH_G;
               pix_d   = '0;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (accept) begin
               if (in_sof) begin
                  // Resynchronise in the same back bank; no swap happens.
                  sync_err_d = !(phase_q == PH_R && pix_q == '0);
                  phase_d    = PH_G;
                  pix_d      = '0;
               end else begin
                  case (phase_q)
                     PH_R:    phase_d = PH_G;
                     PH_G:    phase_d = PH_B;
                     default: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {~disp_bank_q, pix_q[PIX_W-2:0]};
                        wr_data_d = pack_data;
                        wr_mask_d = pack_mask;
                        phase_d   = PH_R;
                        if (pix_q == PIX_LAST) begin
                           pix_d   = '0;
                           state_d = ST_FULL;
                        end else begin
                           pix_d = pix_q + PIX_W'(1);
                        end
                     end
                  endcase
               end
            end
         end

         ST_FULL: begin
            // Checked from the cycle after the last B accept, which is the
            // cycle the final write is on the bus, so it always lands first.
            if (is_boundary(scan_fc, scan_addr, LAST_ROW_L)) begin
               disp_bank_d = ~disp_bank_q;
               swap_d      = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pin_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         phase_q     <= PH_R;
         pix_q       <= '0;
         disp_bank_q <= 1'b0;
         swap_q      <= 1'b0;
         sync_err_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_mask_q   <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         pix_q       <= pix_d;
         disp_bank_q <= disp_bank_d;
         swap_q      <= swap_d;
         sync_err_q  <= sync_err_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_mask_q   <= wr_mask_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign wr_mask    = wr_mask_q;
   assign disp_bank  = disp_bank_q;
   assign swap_pulse = swap_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_hub_fbload.sv
// ---------------------------------------------------------------------------
// tb_hub_fbload
// Self-checking bench for hub_fbload (DEPTH=4, LAST_ROW=15). A behavioural
// model turns every driven byte into expected RAM writes on a queue; a
// negedge monitor pops and compares each write. A small vector table
// cross-checks channel truncation, and hand sequences cover sync errors,
// bank swaps, the last-write/swap ordering and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_hub_fbload;

   logic        pin_clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_sof;
   logic        in_ready;
   logic [11:0] scan_addr;
   logic        scan_fc;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [23:0] wr_data;
   logic [1:0]  wr_mask;
   logic        disp_bank;
   logic        swap_pulse;
   logic        sync_err;

   always #5 pin_clk = ~pin_clk;

   hub_fbload #(.DEPTH(4), .LAST_ROW(15)) dut (
      .pin_clk    (pin_clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_ready   (in_ready),
      .scan_addr  (scan_addr),
      .scan_fc    (scan_fc),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_mask    (wr_mask),
      .disp_bank  (disp_bank),
      .swap_pulse (swap_pulse),
      .sync_err   (sync_err)
   );

   typedef struct {
      logic [12:0] addr;
      logic [23:0] data;
      logic [1:0]  mask;
   } wr_t;

   typedef struct {
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic [11:0] pix;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[6];

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int n_sync   = 0;
   int n_swap   = 0;

   // model state: 0 idle, 1 load, 2 full
   int          m_state;
   int          m_p;
   int          m_ph;
   logic [7:0]  m_r;
   logic [7:0]  m_g;
   logic        m_disp;
   logic        use_tab;
   logic [11:0] tab_pix;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] pack(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
      return {r[7:4], g[7:4], b[7:4]};
   endfunction

   task automatic model_byte(input logic [7:0] d, input logic sof);
      logic [11:0] px;
      logic [12:0] pp;
      wr_t         w;
      if (m_state == 2) return;
      if (sof) begin
         m_r = d; m_ph = 1; m_p = 0; m_state = 1;
      end else if (m_state == 1) begin
         case (m_ph)
            0: begin m_r = d; m_ph = 1; end
            1: begin m_g = d; m_ph = 2; end
            default: begin
               px     = use_tab ? tab_pix : pack(m_r, m_g, d);
               pp     = 13'(m_p);
               w.addr = {~m_disp, pp[11:0]};
               w.data = pp[12] ? {px, 12'h000} : {12'h000, px};
               w.mask = pp[12] ? 2'b10 : 2'b01;
               exp_q.push_back(w);
               m_ph = 0;
               m_p++;
               if (m_p == 8192) begin m_p = 0; m_state = 2; end
            end
         endcase
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic sof);
      in_data  = d;
      in_sof   = sof;
      in_valid = 1'b1;
      model_byte(d, sof);
      @(posedge pin_clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge pin_clk);
         #1;
      end
   endtask

   task automatic send_pixel(input int p, input logic sof);
      logic [12:0] pp;
      pp = 13'(p);
      send_byte(pp[7:0] ^ 8'h5A, sof);
      if (p % 97 == 13) idle(1);
      send_byte(pp[12:5], 1'b0);
      send_byte(8'(p * 37), 1'b0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"},   in_ready,   1);
      check({tag, "_wr_en"},      wr_en,      0);
      check({tag, "_wr_addr"},    wr_addr,    0);
      check({tag, "_wr_data"},    wr_data,    0);
      check({tag, "_wr_mask"},    wr_mask,    0);
      check({tag, "_disp_bank"},  disp_bank,  0);
      check({tag, "_swap_pulse"}, swap_pulse, 0);
      check({tag, "_sync_err"},   sync_err,   0);
   endtask

   // Write monitor / scoreboard
   always @(negedge pin_clk) begin : mon
      wr_t e;
      if (wr_en === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            check("write", {wr_addr, wr_data, wr_mask}, {e.addr, e.data, e.mask});
         end
      end
      if (sync_err === 1'b1)   n_sync++;
      if (swap_pulse === 1'b1) n_swap++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'hFF, 8'h80, 8'h01, 12'hF80};
      vecs[1] = '{8'h12, 8'h34, 8'h56, 12'h135};
      vecs[2] = '{8'h0F, 8'hF0, 8'hA5, 12'h0FA};
      vecs[3] = '{8'h7F, 8'h80, 8'hFF, 12'h78F};
      vecs[4] = '{8'h00, 8'h00, 8'h00, 12'h000};
      vecs[5] = '{8'hC3, 8'h3C, 8'h99, 12'hC39};

      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
      scan_fc = 1'b0; scan_addr = 12'h000;
      m_state = 0; m_p = 0; m_ph = 0; m_r = 0; m_g = 0; m_disp = 1'b0;
      use_tab = 1'b0; tab_pix = 12'h000;
      repeat (3) @(posedge pin_clk);
      #1 rst = 1'b0;
      @(negedge pin_clk);
      check_reset("reset");

      // bytes before any in_sof are dropped
      for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
      idle(2);
      check("no_write_before_sof", n_writes, 0);

      // frame 1: table pixels first
      for (int i = 0; i < 6; i++) begin
         use_tab = 1'b1;
         tab_pix = vecs[i].pix;
         send_byte(vecs[i].r, i == 0);
         if (i == 2) idle(3);
         send_byte(vecs[i].g, 1'b0);
         send_byte(vecs[i].b, 1'b0);
         use_tab = 1'b0;
         if (i == 0) begin
            @(negedge pin_clk);
            check("first_wr_addr", wr_addr, 13'h1000);
            check("first_wr_data", wr_data[11:0], 12'hF80);
            check("first_wr_mask", wr_mask, 2'b01);
         end
      end
      for (int p = 6; p < 100; p++) send_pixel(p, 1'b0);

      // in_sof at p=100, phase G
      send_byte(8'h11, 1'b0);
      send_byte(8'hFF, 1'b1);
      @(negedge pin_clk);
      check("sync_err_pulse", sync_err, 1);
      send_byte(8'h80, 1'b0);
      send_byte(8'h01, 1'b0);
      @(negedge pin_clk);
      check("restart_wr_en", wr_en, 1);
      check("restart_wr_addr", wr_addr, 13'h1000);
      check("sync_err_one_cycle", sync_err, 0);

      for (int p = 1; p < 8192; p++) begin
         if (p == 50) begin scan_addr = 12'hFFF; scan_fc = 1'b1; end
         send_pixel(p, 1'b0);
         scan_fc = 1'b0;
         if (p == 4096) begin
            @(negedge pin_clk);
            check("p4096_wr_mask", wr_mask, 2'b10);
            check("p4096_wr_addr", wr_addr, 13'h1000);
         end
      end
      @(negedge pin_clk);
      check("full_in_ready", in_ready, 0);
      check("strobe_outside_full_ignored", disp_bank, 0);

      // FULL with valid held high: nothing accepted, in_sof ignored
      for (int i = 0; i < 8; i++) send_byte(8'h33, i == 3);
      check("full_still_not_ready", in_ready, 0);
      check("no_sync_err_in_full", n_sync, 1);
      check("frame1_writes_drained", exp_q.size(), 0);

      // strobe on row 5: no swap
      scan_addr = 12'h5FF; scan_fc = 1'b1;
      idle(1);
      scan_fc = 1'b0;
      @(negedge pin_clk);
      check("row5_no_swap_bank", disp_bank, 0);
      check("row5_no_swap_pulse", swap_pulse, 0);

      // strobe on last row: swap
      scan_addr = 12'hFFF; scan_fc = 1'b1;
      idle(1);
      scan_fc = 1'b0;
      @(negedge pin_clk);
      check("swap_bank", disp_bank, 1);
      check("swap_pulse", swap_pulse, 1);
      check("swap_in_ready", in_ready, 1);
      m_disp = 1'b1; m_state = 0;
      @(negedge pin_clk);
      check("swap_pulse_one_cycle", swap_pulse, 0);

      // frame 2 into bank 0, reset at p=3000
      for (int p = 0; p < 3000; p++) send_pixel(p, p == 0);
      send_byte(8'h77, 1'b0);
      @(negedge pin_clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_disp_bank", disp_bank, 0);
      check("rst_pending_writes", exp_q.size(), 0);
      exp_q.delete();
      m_state = 0; m_p = 0; m_ph = 0; m_disp = 1'b0;
      @(posedge pin_clk);
      #1 rst = 1'b0;
      @(negedge pin_clk);
      check_reset("midframe_rst");

      // frame 3: restarts at bank 1 word 0; last B just before the strobe
      for (int p = 0; p < 8192; p++) begin
         send_pixel(p, p == 0);
         if (p == 0) begin
            @(negedge pin_clk);
            check("post_rst_first_wr", wr_addr, 13'h1000);
         end
      end
      scan_addr = 12'hFFF; scan_fc = 1'b1;
      @(negedge pin_clk);
      check("last_wr_en", wr_en, 1);
      check("last_wr_addr", wr_addr, 13'h1FFF);
      check("last_wr_before_swap", disp_bank, 0);
      @(posedge pin_clk);
      #1 scan_fc = 1'b0;
      @(negedge pin_clk);
      check("late_swap_bank", disp_bank, 1);
      check("late_swap_pulse", swap_pulse, 1);
      check("late_swap_no_write", wr_en, 0);

      idle(3);
      check("all_writes_seen", exp_q.size(), 0);
      check("sync_err_total", n_sync, 1);
      check("swap_total", n_swap, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
